// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two cache-controller ports, the shared RAM and the arbiter.
// The master modport is the requester/RAM side; the slave modport is the arbiter.
interface ram_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              done0;
  logic [DATA_W-1:0] rdata0;
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              done1;
  logic [DATA_W-1:0] rdata1;
  logic              ram_re;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_rdata,
    input  done0, rdata0, done1, rdata1, ram_re, ram_we, ram_addr, ram_wdata, busy
  );

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_rdata,
    output done0, rdata0, done1, rdata1, ram_re, ram_we, ram_addr, ram_wdata, busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single fixed-latency RAM.
// One access at a time: IDLE -> ACCESS (RAM_LAT cycles) -> DONE -> IDLE.
module ram_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int RAM_LAT = 2
) (
  input  logic         clk,
  input  logic         clr,
  ram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_ACCESS = 3'b010,
    S_DONE   = 3'b100
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(RAM_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic              r_ptr;
  logic              r_win;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic w_req;
  logic w_pick;
  logic w_last;
  logic w_re;
  logic w_we;
  logic w_done0;
  logic w_done1;
  logic w_busy;

  assign w_req  = bus.req0 | bus.req1;
  // On a tie the port that was not served last wins.
  assign w_pick = (bus.req0 & bus.req1) ? ~r_ptr : bus.req1;
  assign w_last = (r_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_re    = 1'b0;
    w_we    = 1'b0;
    w_done0 = 1'b0;
    w_done1 = 1'b0;
    w_busy  = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_req) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        w_re = ~r_we;
        w_we = r_we;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_done0 = ~r_win;
        w_done1 = r_win;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt    <= '0;
      r_ptr    <= 1'b1;
      r_win    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_win   <= w_pick;
            r_ptr   <= w_pick;
            r_we    <= w_pick ? bus.we1    : bus.we0;
            r_addr  <= w_pick ? bus.addr1  : bus.addr0;
            r_wdata <= w_pick ? bus.wdata1 : bus.wdata0;
            r_cnt   <= '0;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt + 4'd1;
          // Read data is valid on the final access edge only.
          if (w_last && !r_we) begin
            if (r_win) r_rdata1 <= bus.ram_rdata;
            else       r_rdata0 <= bus.ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ram_re    = w_re;
  assign bus.ram_we    = w_we;
  assign bus.ram_addr  = r_addr;
  assign bus.ram_wdata = r_wdata;
  assign bus.done0     = w_done0;
  assign bus.done1     = w_done1;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.busy      = w_busy;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level model compared every cycle, plus
// directed scenarios with literal expectations (RAM_LAT=2 main DUT, RAM_LAT=1 second DUT).
module tb_ram_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus  ();
  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT)) dut  (.clk(clk), .clr(clr), .bus(bus));
  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(1))   dut1 (.clk(clk), .clr(clr), .bus(bus1));

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ram_init(input logic [AW-1:0] a);
    return (a == 8'h3C) ? 16'hBEEF : {a, ~a};
  endfunction

  // RAM seen by the DUTs: fixed contents overlaid by anything written.
  logic [DW-1:0] mem [256];
  bit            mem_wr [256];
  always @(posedge clk) begin
    if (bus.ram_we) begin
      mem[bus.ram_addr]    <= bus.ram_wdata;
      mem_wr[bus.ram_addr] <= 1'b1;
    end
  end
  assign bus.ram_rdata  = mem_wr[bus.ram_addr]  ? mem[bus.ram_addr]  : ram_init(bus.ram_addr);
  assign bus1.ram_rdata = mem_wr[bus1.ram_addr] ? mem[bus1.ram_addr] : ram_init(bus1.ram_addr);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, req, $time);
  endtask

  // Model: m_phase counts cycles since the grant (0 idle, 1..LAT access, LAT+1 done).
  int            m_phase = 0;
  bit            m_ptr   = 1'b1;
  bit            m_win   = 1'b0;
  bit            m_we    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rd0   = '0;
  logic [DW-1:0] m_rd1   = '0;
  logic [DW-1:0] m_mem [256];
  bit            m_wr  [256];

  function automatic bit pick(input bit r0, input bit r1, input bit ptr);
    return (r0 && r1) ? !ptr : r1;
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    return m_wr[a] ? m_mem[a] : ram_init(a);
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_phase <= 0;
      m_ptr   <= 1'b1;
      m_win   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_rd0   <= '0;
      m_rd1   <= '0;
    end else if (m_phase == 0) begin
      if (bus.req0 || bus.req1) begin
        m_phase <= 1;
        m_win   <= pick(bus.req0, bus.req1, m_ptr);
        m_ptr   <= pick(bus.req0, bus.req1, m_ptr);
        m_we    <= pick(bus.req0, bus.req1, m_ptr) ? bus.we1    : bus.we0;
        m_addr  <= pick(bus.req0, bus.req1, m_ptr) ? bus.addr1  : bus.addr0;
        m_wdata <= pick(bus.req0, bus.req1, m_ptr) ? bus.wdata1 : bus.wdata0;
      end
    end else if (m_phase == LAT) begin
      m_phase <= LAT + 1;
      if (m_we) begin
        m_mem[m_addr] <= m_wdata;
        m_wr[m_addr]  <= 1'b1;
      end else if (m_win) m_rd1 <= m_read(m_addr);
      else                m_rd0 <= m_read(m_addr);
    end else if (m_phase > LAT) m_phase <= 0;
    else m_phase <= m_phase + 1;
  end

  always @(posedge clk) begin
    logic [60:0] a_vec;
    logic [60:0] e_vec;
    bit          acc;
    #2;
    acc   = (m_phase >= 1) && (m_phase <= LAT);
    e_vec = {acc && !m_we, acc && m_we, (m_phase == LAT + 1) && !m_win,
             (m_phase == LAT + 1) && m_win, m_phase != 0, m_addr, m_wdata, m_rd0, m_rd1};
    a_vec = {bus.ram_re, bus.ram_we, bus.done0, bus.done1, bus.busy,
             bus.ram_addr, bus.ram_wdata, bus.rdata0, bus.rdata1};
    chk("cycle_model", 64'(a_vec), 64'(e_vec));
    chk("exclusive", {62'd0, bus.ram_re & bus.ram_we, bus.done0 & bus.done1}, 64'd0);
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1;
    int seq[$];
    int tq[$];
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
    bus1.req0 = 0; bus1.we0 = 0; bus1.addr0 = '0; bus1.wdata0 = '0;
    bus1.req1 = 0; bus1.we1 = 0; bus1.addr1 = '0; bus1.wdata1 = '0;
    clr = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_re_we", {bus.ram_re, bus.ram_we}, 0);
    chk("rst_done", {bus.done0, bus.done1}, 0);
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_rdata", {bus.rdata0, bus.rdata1}, 0);
    clr = 1'b0;

    // write on port 1, inputs disturbed during the access
    bus.req1 = 1; bus.we1 = 1; bus.addr1 = 8'h10; bus.wdata1 = 16'h1234;
    @(negedge clk);
    bus.req1 = 0; bus.we1 = 0; bus.wdata1 = 16'hFFFF;
    chk("wr_we_c1", {bus.ram_we, bus.ram_re}, 2'b10);
    chk("wr_addr_c1", bus.ram_addr, 8'h10);
    chk("wr_wdata_c1", bus.ram_wdata, 16'h1234);
    @(negedge clk);
    chk("wr_we_c2", {bus.ram_we, bus.ram_re}, 2'b10);
    chk("wr_data_c2", {bus.ram_addr, bus.ram_wdata}, {8'h10, 16'h1234});
    @(negedge clk);
    chk("wr_done", {bus.done0, bus.done1}, 2'b01);
    chk("wr_re_we_off", {bus.ram_re, bus.ram_we}, 0);
    chk("wr_rdata1", bus.rdata1, 0);
    @(negedge clk);
    chk("wr_done_off", {bus.done0, bus.done1, bus.busy}, 0);

    // single read on port 0
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h3C;
    @(negedge clk);
    bus.req0 = 0; bus.addr0 = 8'h77; bus.we0 = 1;
    chk("rd_c1", {bus.ram_re, bus.ram_we, bus.busy, bus.done0}, 4'b1010);
    chk("rd_addr_c1", bus.ram_addr, 8'h3C);
    @(negedge clk);
    chk("rd_c2", {bus.ram_re, bus.ram_we, bus.done0}, 3'b100);
    chk("rd_addr_c2", bus.ram_addr, 8'h3C);
    @(negedge clk);
    chk("rd_done", {bus.done0, bus.done1, bus.ram_re, bus.ram_we}, 4'b1000);
    chk("rd_rdata0", bus.rdata0, 16'hBEEF);
    chk("rd_rdata1", bus.rdata1, 0);
    chk("rd_addr_hold", bus.ram_addr, 8'h3C);
    @(negedge clk);
    chk("rd_idle", {bus.done0, bus.busy}, 0);
    bus.we0 = 0;

    // reset in the second access cycle
    bus.req0 = 1; bus.addr0 = 8'h21;
    @(negedge clk);
    bus.req0 = 0;
    @(negedge clk);
    #1 clr = 1'b1;
    #1;
    chk("clr_now", {bus.ram_re, bus.busy, bus.done0}, 0);
    chk("clr_addr", bus.ram_addr, 0);
    @(negedge clk);
    chk("clr_nodone", {bus.done0, bus.done1}, 0);
    chk("clr_rdata0", bus.rdata0, 0);
    clr = 1'b0;

    // tie after reset
    bus.addr0 = 8'h3C; bus.addr1 = 8'h10;
    bus.req0 = 1; bus.req1 = 1;
    t0 = -1; t1 = -1;
    for (int c = 0; c < 30 && (t0 < 0 || t1 < 0); c++) begin
      @(negedge clk);
      if (bus.done0 && t0 < 0) begin t0 = c; bus.req0 = 0; end
      if (bus.done1 && t1 < 0) begin t1 = c; bus.req1 = 0; end
    end
    bus.req0 = 0; bus.req1 = 0;
    chk("tie_done0_time", 64'(t0), 64'(2));
    chk("tie_gap", 64'(t1 - t0), 64'(4));
    chk("tie_rdata1", bus.rdata1, 16'h1234);
    @(negedge clk);

    // fairness with both ports requesting continuously
    bus.req0 = 1; bus.req1 = 1;
    for (int c = 0; c < 60 && seq.size() < 6; c++) begin
      @(negedge clk);
      if (bus.done0) begin seq.push_back(0); tq.push_back(c); end
      if (bus.done1) begin seq.push_back(1); tq.push_back(c); end
      if (seq.size() == 6) begin bus.req0 = 0; bus.req1 = 0; end
    end
    bus.req0 = 0; bus.req1 = 0;
    chk("fair_count", 64'(seq.size()), 64'(6));
    for (int i = 0; i < seq.size(); i++) chk("fair_grant", 64'(seq[i]), 64'(i % 2));
    for (int i = 1; i < tq.size(); i++) chk("fair_period", 64'(tq[i] - tq[i-1]), 64'(4));
    repeat (2) @(negedge clk);
    chk("fair_idle", bus.busy, 0);

    // single-cycle RAM latency
    bus1.req0 = 1; bus1.we0 = 0; bus1.addr0 = 8'h3C;
    @(negedge clk);
    bus1.req0 = 0;
    chk("l1_access", {bus1.ram_re, bus1.done0, bus1.busy}, 3'b101);
    chk("l1_addr", bus1.ram_addr, 8'h3C);
    @(negedge clk);
    chk("l1_done", {bus1.done0, bus1.done1, bus1.ram_re}, 3'b100);
    chk("l1_rdata0", bus1.rdata0, 16'hBEEF);
    @(negedge clk);
    chk("l1_idle", {bus1.done0, bus1.busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
